// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, requests the icache, and registers the
// instruction/next-PC pair for an enable-less IF/ID latch (holds on stall, bubbles otherwise).
module fetch_pc_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] npc_q;
  logic        valid_q;
  logic [31:0] buf_q;
  logic [31:0] buf_npc_q;
  logic [31:0] pc_d;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc_d     = pc_q + 32'd4;

  assign imemREN  = (state_q == FETCH);
  assign imemaddr = pc_q;
  assign if_instr = instr_q;
  assign if_npc   = npc_q;
  assign if_valid = valid_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      instr_q   <= '0;
      npc_q     <= '0;
      valid_q   <= 1'b0;
      buf_q     <= '0;
      buf_npc_q <= '0;
    end else if (state_q != HALTED) begin
      if (redirect) begin
        // Flush overrides stall: the latch must not keep a wrong-path instruction.
        pc_q    <= {redirect_pc[31:2], 2'b00};
        instr_q <= '0;
        npc_q   <= '0;
        valid_q <= 1'b0;
        state_q <= FETCH;
      end else if (halt) begin
        instr_q <= '0;
        npc_q   <= '0;
        valid_q <= 1'b0;
        state_q <= HALTED;
      end else if (state_q == HOLD) begin
        if (!stall) begin
          instr_q <= buf_q;
          npc_q   <= buf_npc_q;
          valid_q <= 1'b1;
          state_q <= FETCH;
        end
      end else if (stall) begin
        // Park the hit so the request is not repeated while IF/ID is frozen.
        if (ihit) begin
          buf_q     <= imemload;
          buf_npc_q <= pc_d;
          pc_q      <= pc_d;
          state_q   <= HOLD;
        end
      end else if (ihit) begin
        instr_q <= imemload;
        npc_q   <= pc_d;
        valid_q <= 1'b1;
        pc_q    <= pc_d;
      end else begin
        instr_q <= '0;
        npc_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a queue-based reference model predicts the
// post-edge outputs each cycle and a monitor compares them against the DUT.
module tb_fetch_pc_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        if_valid;

  fetch_pc_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .if_instr(if_instr),
    .if_npc(if_npc), .if_valid(if_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: fetched-but-not-delivered words sit in a queue.
  logic [31:0] m_pc = PC_INIT;
  logic [31:0] m_instr = '0;
  logic [31:0] m_npc = '0;
  logic        m_valid = 1'b0;
  bit          m_halted = 1'b0;
  logic [63:0] held[$];

  function automatic void m_reset();
    m_pc = PC_INIT; m_instr = '0; m_npc = '0; m_valid = 1'b0;
    m_halted = 1'b0; held.delete();
  endfunction

  function automatic void m_bubble();
    m_instr = '0; m_npc = '0; m_valid = 1'b0;
  endfunction

  function automatic void m_step();
    logic [63:0] w;
    if (m_halted) return;
    if (redirect) begin
      m_pc = redirect_pc & ~32'd3;
      m_bubble();
      held.delete();
    end else if (halt) begin
      m_halted = 1'b1;
      m_bubble();
      held.delete();
    end else if (held.size() != 0) begin
      if (!stall) begin
        w = held.pop_front();
        m_instr = w[63:32]; m_npc = w[31:0]; m_valid = 1'b1;
      end
    end else if (ihit) begin
      if (stall) held.push_back({imemload, m_pc + 32'd4});
      else begin
        m_instr = imemload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_bubble();
    end
  endfunction

  always @(posedge RST) m_reset();

  always @(posedge CLK) begin
    if (RST) m_reset();
    else m_step();
    exp_q.push_back({!m_halted && held.size() == 0, m_pc, m_instr, m_npc, m_valid});
  end

  // Monitor
  always @(posedge CLK) begin
    obs_t e, a;
    #1;
    total++;
    a = {imemREN, imemaddr, if_instr, if_npc, if_valid};
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty t=%0t got ren=%b addr=%h instr=%h npc=%h v=%b",
               $time, a.ren, a.addr, a.instr, a.npc, a.valid);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got ren=%b addr=%h instr=%h npc=%h v=%b want ren=%b addr=%h instr=%h npc=%h v=%b",
                 $time, a.ren, a.addr, a.instr, a.npc, a.valid,
                 e.ren, e.addr, e.instr, e.npc, e.valid);
      end
    end
  end

  task automatic cyc(input bit h, input logic [31:0] ld, input bit st,
                     input bit rd, input logic [31:0] rp, input bit ht);
    @(negedge CLK);
    ihit = h; imemload = ld; stall = st; redirect = rd; redirect_pc = rp; halt = ht;
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST = 1'b1; ihit = 0; stall = 0; redirect = 0; halt = 0;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    obs_t a;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'hAAAA_0001, 0, 0, 0, 0);
    cyc(1, 32'hBBBB_0002, 0, 0, 0, 0);
    cyc(1, 32'hCCCC_0003, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h1234_5678, 0, 0, 0, 0);
    cyc(1, 32'hDDDD_0004, 1, 0, 0, 0);
    cyc(1, 32'hEEEE_EEEE, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h5555_0005, 0, 0, 0, 0);
    cyc(1, 32'h6666_0006, 1, 1, 32'h0000_0103, 0);
    cyc(1, 32'h7777_0007, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    // Asynchronous reset while holding a captured hit
    @(negedge CLK);
    RST = 1'b1; ihit = 0; stall = 0;
    #1;
    total++;
    a = {imemREN, imemaddr, if_instr, if_npc, if_valid};
    if (a !== {1'b1, PC_INIT, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got ren=%b addr=%h instr=%h npc=%h v=%b want ren=1 addr=%h instr=0 npc=0 v=0",
               a.ren, a.addr, a.instr, a.npc, a.valid, PC_INIT);
    end
    @(negedge CLK);
    RST = 1'b0;
    cyc(1, 32'h1111_0001, 0, 1, 32'hFFFF_FFFE, 0);
    cyc(1, 32'h2222_0002, 0, 0, 0, 0);
    cyc(1, 32'h3333_0003, 0, 0, 0, 0);
    cyc(1, 32'h4444_0004, 0, 0, 0, 1);
    cyc(1, 32'h4444_0005, 0, 1, 32'h0000_0200, 0);
    cyc(1, 32'h4444_0006, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset(2);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rp;
      if (m_halted && ($urandom % 6 == 0)) do_reset(1 + $urandom % 2);
      else if ($urandom % 200 == 0) do_reset(1);
      else begin
        rp = $urandom;
        if ($urandom % 4 == 0) rp = 32'hFFFF_FFF0 | ($urandom % 16);
        cyc($urandom % 4 != 0, $urandom, $urandom % 4 == 0,
            $urandom % 16 == 0, rp, $urandom % 64 == 0);
      end
    end

    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
